// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the split-transaction bus arbiter.
// No ports; provides the FSM state enum, sizing constants and the owner-index width helper.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESUME_WAIT,
    RESUME
  } arb_state_t;

  localparam int unsigned MAX_INIT = 8;
  localparam int unsigned CNT_W    = 4;

  // Width of an initiator index for n initiators.
  function automatic int unsigned owner_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/bus_split_arbiter_if.sv
// Bus-side signal bundle between the initiator ports, the split target and the arbiter.
// slave modport: arbiter view (requests/acks in, grants/status out).
// master modport: initiator/target view (drives requests/acks, observes grants/status).
interface bus_split_arbiter_if #(
  parameter int unsigned N_INIT = 2
);
  import bus_arb_pkg::*;

  localparam int unsigned OW = owner_w(N_INIT);

  logic [N_INIT-1:0] req;
  logic [N_INIT-1:0] grant;
  logic              bus_s_ack;
  logic              bus_split_ack;
  logic              split_req;
  logic              split_grant;
  logic              split_pending;
  logic [OW-1:0]     split_owner;
  logic              bus_busy;
  logic              split_err;

  modport slave (
    input  req, bus_s_ack, bus_split_ack, split_req,
    output grant, split_grant, split_pending, split_owner, bus_busy, split_err
  );

  modport master (
    output req, bus_s_ack, bus_split_ack, split_req,
    input  grant, split_grant, split_pending, split_owner, bus_busy, split_err
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after start_idx, wrapping.
// Ports: req (request vector), start_idx (search origin), gnt_c (one-hot), idx_c (index),
//        valid_c (any request found).
module arb_rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [owner_w(N)-1:0] start_idx,
  output logic [N-1:0]          gnt_c,
  output logic [owner_w(N)-1:0] idx_c,
  output logic                  valid_c
);

  localparam int unsigned W = owner_w(N);

  // One extra bit so start_idx + offset cannot overflow before the wrap.
  logic [W:0] cand;

  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand = (W+1)'(start_idx) + (W+1)'(i);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (!valid_c && req[cand[W-1:0]]) begin
        valid_c             = 1'b1;
        gnt_c[cand[W-1:0]]  = 1'b1;
        idx_c               = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_split_arbiter.sv
// Round-robin bus arbiter that parks one split initiator and re-grants it when the target
// returns split data, pulsing split_grant after a fixed latency.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carrying req/acks/split_req in
//        and registered grant/split_grant/split_pending/split_owner/bus_busy/split_err out.
module bus_split_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_INIT              = 2,
  parameter int unsigned SPLIT_GRANT_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  bus_split_arbiter_if.slave  bus
);

  localparam int unsigned OW = owner_w(N_INIT);

  arb_state_t        state_q, state_d;
  logic [N_INIT-1:0] grant_q, grant_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     last_q, last_d;
  logic              pend_q, pend_d;
  logic [OW-1:0]     sowner_q, sowner_d;
  logic              sgrant_q, sgrant_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OW-1:0]     start_idx;
  logic [N_INIT-1:0] park_mask;
  logic [N_INIT-1:0] elig;
  logic [N_INIT-1:0] pick_gnt;
  logic [OW-1:0]     pick_idx;
  logic              pick_valid;

  // Search starts just after the last completed owner; the parked initiator is excluded.
  assign start_idx = (last_q == OW'(N_INIT - 1)) ? '0 : last_q + OW'(1);
  assign park_mask = pend_q ? (N_INIT'(1) << sowner_q) : '0;
  assign elig      = bus.req & ~park_mask;

  arb_rr_pick #(.N(N_INIT)) u_pick (
    .req       (elig),
    .start_idx (start_idx),
    .gnt_c     (pick_gnt),
    .idx_c     (pick_idx),
    .valid_c   (pick_valid)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      last_q   <= OW'(N_INIT - 1);
      pend_q   <= 1'b0;
      sowner_q <= '0;
      sgrant_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      sowner_q <= sowner_d;
      sgrant_q <= sgrant_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    last_d   = last_q;
    pend_d   = pend_q;
    sowner_d = sowner_q;
    sgrant_d = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (pend_q && bus.split_req) begin
          cnt_d   = CNT_W'(SPLIT_GRANT_LATENCY);
          state_d = RESUME_WAIT;
        end else if (pick_valid) begin
          grant_d = pick_gnt;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Split takes precedence over a simultaneous normal ack.
        if (bus.bus_split_ack) begin
          if (pend_q) begin
            err_d = 1'b1;
          end else begin
            pend_d   = 1'b1;
            sowner_d = owner_q;
          end
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (bus.bus_s_ack) begin
          last_d  = owner_q;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      RESUME_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          sgrant_d = 1'b1;
          grant_d  = N_INIT'(1) << sowner_q;
          busy_d   = 1'b1;
          state_d  = RESUME;
        end
      end

      RESUME: begin
        if (bus.bus_split_ack) err_d = 1'b1;
        if (bus.bus_s_ack) begin
          pend_d  = 1'b0;
          last_d  = sowner_q;
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.grant         = grant_q;
  assign bus.split_grant   = sgrant_q;
  assign bus.split_pending = pend_q;
  assign bus.split_owner   = sowner_q;
  assign bus.bus_busy      = busy_q;
  assign bus.split_err     = err_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Self-checking bench for bus_split_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_bus_split_arbiter;

  localparam int N   = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_split_arbiter_if #(.N_INIT(N)) bif ();

  bus_split_arbiter #(.N_INIT(N), .SPLIT_GRANT_LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: who owns the bus, the parked split, and the absolute edge of a resume.
  int m_owner;      // -1 when nobody holds the bus
  bit m_resume;     // current ownership is the resumed split
  int m_last;
  bit m_pending;
  int m_sowner;
  bit m_err;
  bit m_sg;
  int m_resume_at;  // edge number at which the resume grant appears, -1 if none
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    m_owner     = -1;
    m_resume    = 1'b0;
    m_last      = N - 1;
    m_pending   = 1'b0;
    m_sowner    = 0;
    m_err       = 1'b0;
    m_sg        = 1'b0;
    m_resume_at = -1;
  endfunction

  task automatic m_edge();
    logic [N-1:0] r;
    bit sa, spa, sr, found, sg_next;
    r   = bif.req;
    sa  = bif.bus_s_ack;
    spa = bif.bus_split_ack;
    sr  = bif.split_req;
    cyc++;
    sg_next = 1'b0;
    if (m_owner >= 0) begin
      if (spa) begin
        if (m_resume) m_err = 1'b1;
        else begin
          if (m_pending) m_err = 1'b1;
          else begin
            m_pending = 1'b1;
            m_sowner  = m_owner;
          end
          m_owner = -1;
        end
      end
      if (m_owner >= 0 && sa) begin
        if (m_resume) begin
          m_pending = 1'b0;
          m_resume  = 1'b0;
        end
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (m_resume_at >= 0) begin
      if (cyc == m_resume_at) begin
        m_owner     = m_sowner;
        m_resume    = 1'b1;
        sg_next     = 1'b1;
        m_resume_at = -1;
      end
    end else if (m_pending && sr) begin
      m_resume_at = cyc + LAT;
    end else begin
      found = 1'b0;
      for (int d = 1; d <= N; d++) begin
        int k;
        k = (m_last + d) % N;
        if (!found && r[k] && !(m_pending && k == m_sowner)) begin
          m_owner = k;
          found   = 1'b1;
        end
      end
    end
    m_sg = sg_next;
  endtask

  task automatic compare_all();
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk("m_grant", 32'(bif.grant), 32'(eg));
    chk("m_busy", 32'(bif.bus_busy), 32'(m_owner >= 0));
    chk("m_split_grant", 32'(bif.split_grant), 32'(m_sg));
    chk("m_split_pending", 32'(bif.split_pending), 32'(m_pending));
    chk("m_split_err", 32'(bif.split_err), 32'(m_err));
    if (m_pending) chk("m_split_owner", 32'(bif.split_owner), 32'(m_sowner));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) m_edge();
    else m_reset();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    compare_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bif.req           = '0;
    bif.bus_s_ack     = 1'b0;
    bif.bus_split_ack = 1'b0;
    bif.split_req     = 1'b0;
    rst_n             = 1'b0;
    m_reset();
    repeat (2) step();

    // Reset values
    chk("rst_grant", 32'(bif.grant), 32'd0);
    chk("rst_busy", 32'(bif.bus_busy), 32'd0);
    chk("rst_sg", 32'(bif.split_grant), 32'd0);
    chk("rst_pending", 32'(bif.split_pending), 32'd0);
    chk("rst_owner", 32'(bif.split_owner), 32'd0);
    chk("rst_err", 32'(bif.split_err), 32'd0);
    rst_n = 1'b1;
    step();

    // Single initiator
    bif.req = 2'b01;
    step();
    chk("single_grant", 32'(bif.grant), 32'd1);
    chk("single_busy", 32'(bif.bus_busy), 32'd1);
    bif.req = 2'b00;
    repeat (4) step();
    chk("single_hold", 32'(bif.grant), 32'd1);
    bif.bus_s_ack = 1'b1;
    step();
    bif.bus_s_ack = 1'b0;
    chk("single_release", 32'(bif.grant), 32'd0);
    chk("single_busy_off", 32'(bif.bus_busy), 32'd0);

    // Round robin with one idle cycle between owners
    do_reset();
    bif.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rr_grant%0d", i), 32'(bif.grant), (i % 2 == 0) ? 32'd1 : 32'd2);
      repeat (2) step();
      bif.bus_s_ack = 1'b1;
      step();
      bif.bus_s_ack = 1'b0;
      chk($sformatf("rr_gap%0d", i), 32'(bif.grant), 32'd0);
    end
    bif.req = 2'b00;

    // Split and resume with latency 2
    do_reset();
    bif.req = 2'b01;
    step();
    chk("split_g0", 32'(bif.grant), 32'd1);
    bif.req = 2'b00;
    bif.bus_split_ack = 1'b1;
    step();
    bif.bus_split_ack = 1'b0;
    chk("split_pending", 32'(bif.split_pending), 32'd1);
    chk("split_owner", 32'(bif.split_owner), 32'd0);
    chk("split_released", 32'(bif.grant), 32'd0);
    bif.req = 2'b10;
    step();
    chk("split_other_g1", 32'(bif.grant), 32'd2);
    bif.req = 2'b00;
    bif.bus_s_ack = 1'b1;
    step();
    bif.bus_s_ack = 1'b0;
    bif.split_req = 1'b1;
    step();
    chk("resume_wait0", 32'(bif.grant), 32'd0);
    step();
    chk("resume_wait1_sg", 32'(bif.split_grant), 32'd0);
    step();
    chk("resume_sg", 32'(bif.split_grant), 32'd1);
    chk("resume_grant", 32'(bif.grant), 32'd1);
    bif.split_req = 1'b0;
    step();
    chk("resume_sg_pulse", 32'(bif.split_grant), 32'd0);
    bif.bus_s_ack = 1'b1;
    step();
    bif.bus_s_ack = 1'b0;
    chk("resume_clear", 32'(bif.split_pending), 32'd0);

    // Resume has priority over a normal request
    bif.req = 2'b01;
    step();
    bif.req = 2'b00;
    bif.bus_split_ack = 1'b1;
    step();
    bif.bus_split_ack = 1'b0;
    bif.split_req = 1'b1;
    bif.req = 2'b10;
    step();
    chk("prio_no_grant", 32'(bif.grant), 32'd0);
    step();
    step();
    chk("prio_resume_grant", 32'(bif.grant), 32'd1);
    bif.split_req = 1'b0;
    step();
    bif.bus_s_ack = 1'b1;
    step();
    bif.bus_s_ack = 1'b0;
    step();
    chk("prio_then_g1", 32'(bif.grant), 32'd2);
    bif.req = 2'b00;
    bif.bus_s_ack = 1'b1;
    step();
    bif.bus_s_ack = 1'b0;

    // Second split while one is outstanding
    do_reset();
    bif.req = 2'b01;
    step();
    bif.req = 2'b00;
    bif.bus_split_ack = 1'b1;
    step();
    bif.bus_split_ack = 1'b0;
    bif.req = 2'b10;
    step();
    chk("err_g1", 32'(bif.grant), 32'd2);
    bif.req = 2'b00;
    bif.bus_split_ack = 1'b1;
    step();
    bif.bus_split_ack = 1'b0;
    chk("err_set", 32'(bif.split_err), 32'd1);
    chk("err_owner", 32'(bif.split_owner), 32'd0);
    chk("err_released", 32'(bif.grant), 32'd0);
    repeat (2) step();
    chk("err_sticky", 32'(bif.split_err), 32'd1);

    // Reset in the middle of the resume countdown
    bif.split_req = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rstmid_grant", 32'(bif.grant), 32'd0);
    chk("rstmid_pending", 32'(bif.split_pending), 32'd0);
    chk("rstmid_err", 32'(bif.split_err), 32'd0);
    step();
    chk("rstmid_sg", 32'(bif.split_grant), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rstmid_after_sg", 32'(bif.split_grant), 32'd0);
    chk("rstmid_after_grant", 32'(bif.grant), 32'd0);
    bif.split_req = 1'b0;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      bif.req           = N'($urandom);
      bif.bus_s_ack     = ($urandom_range(0, 3) == 0);
      bif.bus_split_ack = ($urandom_range(0, 11) == 0);
      if (!bif.split_req) bif.split_req = ($urandom_range(0, 7) == 0);
      else if (bif.split_grant) bif.split_req = 1'b0;
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
